// File: rtl/freq_counter_gated.sv
// Multi-channel gated frequency counter: counts synchronized rising edges per
// channel over a gate_len-cycle window and publishes saturated counts with a valid strobe.
module freq_counter_gated #(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GATE_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                continuous,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic [CH-1:0]       sig_in,
  output logic [CH*CNT_W-1:0] count_out,
  output logic [CH-1:0]       overflow,
  output logic                valid,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

  state_t               state_q;
  logic [CH-1:0]        sync_q [SYNC_STAGES];
  logic [CH-1:0]        prev_q;
  logic [CNT_W-1:0]     cnt_q  [CH];
  logic [CNT_W-1:0]     cnt_d  [CH];
  logic [CNT_W:0]       inc    [CH];
  logic [CH-1:0]        sticky_q;
  logic [CH-1:0]        sat;
  logic [CH-1:0]        rise;
  logic [GATE_W-1:0]    timer_q;
  logic [GATE_W-1:0]    gate_eff;
  logic [CH*CNT_W-1:0]  count_q;
  logic [CH-1:0]        ovf_q;
  logic                 valid_q;
  logic                 busy_q;

  assign count_out = count_q;
  assign overflow  = ovf_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gate_eff = (gate_len == '0) ? GATE_W'(1) : gate_len;

  // Increment one bit wider than the counter so the carry flags saturation.
  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
      inc[k]   = {1'b0, cnt_q[k]} + {{CNT_W{1'b0}}, rise[k]};
      sat[k]   = inc[k][CNT_W];
      cnt_d[k] = sat[k] ? cnt_q[k] : inc[k][CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      for (int unsigned k = 0; k < CH; k++) cnt_q[k] <= '0;
      sticky_q <= '0;
      timer_q  <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && enable) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          for (int unsigned k = 0; k < CH; k++) cnt_q[k] <= '0;
          sticky_q <= '0;
          if (!enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= gate_eff;
            state_q <= GATE;
          end
        end
        GATE: begin
          if (!enable) begin
            for (int unsigned k = 0; k < CH; k++) cnt_q[k] <= '0;
            sticky_q <= '0;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else if (timer_q == GATE_W'(1)) begin
            // Final cycle's edge is folded into the published count; counters
            // restart from zero so the next cycle's edge opens the new window.
            for (int unsigned k = 0; k < CH; k++) begin
              count_q[k*CNT_W +: CNT_W] <= cnt_d[k];
              cnt_q[k] <= '0;
            end
            ovf_q    <= sticky_q | sat;
            sticky_q <= '0;
            valid_q  <= 1'b1;
            if (continuous) begin
              timer_q <= gate_eff;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            for (int unsigned k = 0; k < CH; k++) cnt_q[k] <= cnt_d[k];
            sticky_q <= sticky_q | sat;
            timer_q  <= timer_q - GATE_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter_gated.sv
// Directed bench for freq_counter_gated: an edge-accounting model checked every
// cycle, plus literal expectations for the main scenarios.
module tb_freq_counter_gated;

  localparam int CH     = 4;
  localparam int CNT_W  = 8;
  localparam int GATE_W = 32;
  localparam int S      = 2;
  localparam int MAXC   = 255;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic                start;
  logic                continuous;
  logic [GATE_W-1:0]   gate_len;
  logic [CH-1:0]       sig_in = '0;
  logic [CH*CNT_W-1:0] count_out;
  logic [CH-1:0]       overflow;
  logic                valid;
  logic                busy;

  freq_counter_gated #(.CH(CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .continuous(continuous), .gate_len(gate_len), .sig_in(sig_in),
    .count_out(count_out), .overflow(overflow), .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;
  int per [CH] = '{0, 0, 0, 0};
  int cyc = 0;

  task automatic check(input string name, input longint got, input longint exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Periodic stimulus: one rising edge per period on each active channel.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      for (int k = 0; k < CH; k++)
        sig_in[k] = (per[k] == 0) ? 1'b0 : ((cyc % per[k]) < (per[k] / 2));
    end
  end

  // Model: an edge counts at clock n when sig_in sampled S clocks ago was 1 and
  // S+1 clocks ago was 0. Windows accumulate unbounded totals, clamped on publish.
  logic [CH-1:0] h [S+1];
  int  mstate;
  int  rem;
  int  acc   [CH];
  int  e_cnt [CH];
  logic [CH-1:0] e_ovf;
  logic e_valid, e_busy;

  always @(posedge clock or negedge reset) begin : model
    logic [CH-1:0] r;
    int tot;
    if (!reset) begin
      for (int i = 0; i <= S; i++) h[i] = '0;
      mstate = 0; rem = 0;
      for (int k = 0; k < CH; k++) begin acc[k] = 0; e_cnt[k] = 0; end
      e_ovf = '0; e_valid = 1'b0; e_busy = 1'b0;
    end else begin
      r = h[S-1] & ~h[S];
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = sig_in;
      e_valid = 1'b0;
      case (mstate)
        0: if (start && enable) mstate = 1;
        1: begin
          for (int k = 0; k < CH; k++) acc[k] = 0;
          if (!enable) mstate = 0;
          else begin rem = (gate_len == 0) ? 1 : int'(gate_len); mstate = 2; end
        end
        default: begin
          if (!enable) begin
            for (int k = 0; k < CH; k++) acc[k] = 0;
            mstate = 0;
          end else if (rem == 1) begin
            for (int k = 0; k < CH; k++) begin
              tot = acc[k] + int'(r[k]);
              e_cnt[k] = (tot > MAXC) ? MAXC : tot;
              e_ovf[k] = (tot > MAXC);
              acc[k] = 0;
            end
            e_valid = 1'b1;
            if (continuous) rem = (gate_len == 0) ? 1 : int'(gate_len);
            else mstate = 0;
          end else begin
            for (int k = 0; k < CH; k++) acc[k] = acc[k] + int'(r[k]);
            rem = rem - 1;
          end
        end
      endcase
      e_busy = (mstate != 0);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("valid", valid, e_valid);
      check("busy", busy, e_busy);
      check("overflow", overflow, e_ovf);
      for (int k = 0; k < CH; k++)
        check($sformatf("count%0d", k), count_out[k*CNT_W +: CNT_W], e_cnt[k]);
    end
  end

  function automatic int ch(input int k);
    return int'(count_out[k*CNT_W +: CNT_W]);
  endfunction

  task automatic start_and_wait(input int limit, output int n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (!valid && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("valid_seen", valid, 1);
  endtask

  task automatic wait_next(input int limit, output int n);
    @(negedge clock);
    n = 1;
    while (!valid && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("valid_seen", valid, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_count"}, count_out, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sum, pulses;
    reset = 1'b0; enable = 1'b0; start = 1'b0; continuous = 1'b0; gate_len = '0;
    #2;
    check_zero_outputs("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1; enable = 1'b1; chk_en = 1'b1;
    repeat (5) @(negedge clock);

    // Single shot, ch0 period 4 over 100 cycles
    per[0] = 4;
    repeat (10) @(negedge clock);
    gate_len = 100;
    start_and_wait(200, n);
    check("t1_latency", n, 102);
    check("t1_ch0", ch(0), 25);
    check("t1_ch1", ch(1), 0);
    check("t1_ch3", ch(3), 0);
    check("t1_ovf", overflow, 0);
    check("t1_busy", busy, 0);

    // Saturation then a quiet window
    per[0] = 0; per[1] = 2;
    repeat (10) @(negedge clock);
    gate_len = 1000;
    start_and_wait(1100, n);
    check("t2_ch1", ch(1), 255);
    check("t2_ovf", overflow, 4'b0010);
    per[1] = 0;
    repeat (10) @(negedge clock);
    gate_len = 50;
    start_and_wait(100, n);
    check("t2b_ch1", ch(1), 0);
    check("t2b_ovf", overflow, 0);

    // Continuous windows, ch2 period 5
    per[2] = 5;
    repeat (10) @(negedge clock);
    continuous = 1'b1;
    start_and_wait(100, n);
    check("t3_first_latency", n, 52);
    check("t3_ch2", ch(2), 10);
    sum = ch(2);
    for (int w = 1; w < 4; w++) begin
      wait_next(100, n);
      check("t3_spacing", n, 50);
      check("t3_ch2", ch(2), 10);
      check("t3_busy", busy, 1);
      sum += ch(2);
    end
    check("t3_sum", sum, 40);
    continuous = 1'b0;
    wait_next(100, n);
    check("t3_last_spacing", n, 50);
    check("t3_idle", busy, 0);
    per[2] = 0;

    // gate_len = 0 behaves as 1
    repeat (10) @(negedge clock);
    gate_len = 0;
    start_and_wait(10, n);
    check("t4_latency", n, 3);
    check("t4_ch2", ch(2), 0);

    // Enable abort keeps the previous result
    per[0] = 4;
    repeat (10) @(negedge clock);
    gate_len = 100;
    start_and_wait(200, n);
    check("t5_pre_ch0", ch(0), 25);
    per[0] = 2;
    repeat (10) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("t5_abort_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      if (i == 5) enable = 1'b1;
      @(negedge clock);
      if (valid) pulses++;
    end
    check("t5_no_valid", pulses, 0);
    check("t5_hold_ch0", ch(0), 25);
    per[0] = 4;
    repeat (10) @(negedge clock);
    gate_len = 20;
    start_and_wait(50, n);
    check("t5_restart_latency", n, 22);
    check("t5_restart_ch0", ch(0), 5);

    // Reset mid-window with start held
    gate_len = 100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    start = 1'b1;
    #2 reset = 1'b0;
    #1 check_zero_outputs("t6_async");
    repeat (3) @(negedge clock);
    start = 1'b0;
    #2 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (valid || busy) pulses++;
    end
    check("t6_idle_after_reset", pulses, 0);
    gate_len = 10;
    start_and_wait(30, n);
    check("t6_restart_latency", n, 12);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
